// File: rtl/ts_sched_pkg.sv
// Shared constants, FSM state type and helpers for the TS source scheduler.
package ts_sched_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned PKT_LEN   = 188;
    localparam logic [7:0]  SYNC_BYTE = 8'h47;

    typedef enum logic [0:0] {
        StLocked,
        StPending
    } state_t;

    // Index of the lowest-numbered set bit; 0 when none are set.
    function automatic logic [1:0] lowest_alive(input logic [NUM_CH-1:0] alive);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (alive[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ts_chan_monitor.sv
// Per-channel TS framing tracker and liveness monitor.
// Exposes the combinational next in_pkt / alive so the scheduler can decide
// a switch in the same cycle the packet boundary is reached.
module ts_chan_monitor
    import ts_sched_pkg::*;
#(
    parameter int unsigned PKT_LEN        = ts_sched_pkg::PKT_LEN,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 13
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    input  logic i_sync,
    output logic o_in_pkt_nxt,
    output logic o_alive_nxt,
    output logic o_src_alive,
    output logic o_sync_err
);

    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(PKT_LEN);

    logic [CNT_W-1:0] r_cnt;
    logic             r_in_pkt;
    logic [TO_W-1:0]  r_to;
    logic             r_alive;
    logic             r_sync_err;

    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_in_pkt_d;
    logic [TO_W-1:0]  w_to_d;
    logic             w_alive_d;
    logic             w_sync_err_d;

    assign w_cnt_inc = r_cnt + 1'b1;

    // Next-state for framing counter, packet flag and liveness timer.
    always_comb begin
        w_cnt_d      = r_cnt;
        w_in_pkt_d   = r_in_pkt;
        w_to_d       = r_to;
        w_alive_d    = r_alive;
        w_sync_err_d = 1'b0;
        if (i_valid && i_sync) begin
            w_cnt_d      = CNT_W'(1);
            w_in_pkt_d   = 1'b1;
            w_sync_err_d = r_in_pkt;
            w_to_d       = '0;
            w_alive_d    = 1'b1;
        end else begin
            if (i_valid && r_in_pkt) begin
                if (w_cnt_inc == CNT_END) begin
                    w_cnt_d    = '0;
                    w_in_pkt_d = 1'b0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            if (r_to != TO_MAX) begin
                w_to_d = r_to + 1'b1;
            end
            // A dead channel also drops any half-tracked packet.
            if (w_to_d == TO_MAX) begin
                w_alive_d  = 1'b0;
                w_in_pkt_d = 1'b0;
                w_cnt_d    = '0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_in_pkt   <= 1'b0;
            r_to       <= '0;
            r_alive    <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_d;
            r_in_pkt   <= w_in_pkt_d;
            r_to       <= w_to_d;
            r_alive    <= w_alive_d;
            r_sync_err <= w_sync_err_d;
        end
    end

    assign o_in_pkt_nxt = w_in_pkt_d;
    assign o_alive_nxt  = w_alive_d;
    assign o_src_alive  = r_alive;
    assign o_sync_err   = r_sync_err;

endmodule

// File: rtl/ts_source_scheduler.sv
// Packet-aligned source selector for the 4-channel TS mux.
// A switch commits only when both the current and target channels sit
// between packets, so the downstream FIFO never sees a torn packet.
// Optional build macro AUTO_FAILOVER_EN: when the selected channel dies,
// an internal request retargets the lowest-index live channel.
module ts_source_scheduler
    import ts_sched_pkg::*;
#(
    parameter int unsigned PKT_LEN        = ts_sched_pkg::PKT_LEN,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 13
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] valid_in,
    input  logic [NUM_CH-1:0] sync_in,
    input  logic              req_valid,
    input  logic [1:0]        req_sel,
    output logic              req_ready,
    output logic              req_err,
    output logic              switch_done,
    output logic [1:0]        mux_ctrl,
    output logic [NUM_CH-1:0] src_alive,
    output logic [NUM_CH-1:0] sync_err
);

    logic [NUM_CH-1:0] w_in_pkt_nxt;
    logic [NUM_CH-1:0] w_alive_nxt;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        ts_chan_monitor #(
            .PKT_LEN       (PKT_LEN),
            .CNT_W         (CNT_W),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
            .TO_W          (TO_W)
        ) u_mon (
            .i_clk       (wclk),
            .i_rst       (rst),
            .i_valid     (valid_in[gi]),
            .i_sync      (sync_in[gi]),
            .o_in_pkt_nxt(w_in_pkt_nxt[gi]),
            .o_alive_nxt (w_alive_nxt[gi]),
            .o_src_alive (src_alive[gi]),
            .o_sync_err  (sync_err[gi])
        );
    end

    state_t     r_state;
    logic [1:0] r_mux;
    logic [1:0] r_target;
    logic       r_req_ready;
    logic       r_req_err;
    logic       r_switch_done;

    logic       w_auto_req;
    logic [1:0] w_auto_sel;
    logic       w_commit;
    logic       w_abort;

`ifdef AUTO_FAILOVER_EN
    assign w_auto_req = (r_state == StLocked) && !src_alive[r_mux] && (|src_alive);
    assign w_auto_sel = lowest_alive(src_alive);
`else
    assign w_auto_req = 1'b0;
    assign w_auto_sel = 2'd0;
`endif

    // Current side may also be dead; target must land exactly between packets.
    assign w_commit = (!w_in_pkt_nxt[r_mux] || !src_alive[r_mux]) && !w_in_pkt_nxt[r_target];
    // Evaluated on next-liveness so a same-cycle death beats a commit.
    assign w_abort  = !w_alive_nxt[r_target];

    // Request FSM with registered mux select and status pulses.
    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state       <= StLocked;
            r_mux         <= 2'd0;
            r_target      <= 2'd0;
            r_req_ready   <= 1'b1;
            r_req_err     <= 1'b0;
            r_switch_done <= 1'b0;
        end else begin
            r_req_err     <= 1'b0;
            r_switch_done <= 1'b0;
            case (r_state)
                StLocked: begin
                    if (w_auto_req) begin
                        r_target    <= w_auto_sel;
                        r_state     <= StPending;
                        r_req_ready <= 1'b0;
                    end else if (req_valid) begin
                        if (req_sel == r_mux) begin
                            r_switch_done <= 1'b1;
                        end else if (!src_alive[req_sel]) begin
                            r_req_err <= 1'b1;
                        end else begin
                            r_target    <= req_sel;
                            r_state     <= StPending;
                            r_req_ready <= 1'b0;
                        end
                    end
                end
                StPending: begin
                    if (w_abort) begin
                        r_req_err   <= 1'b1;
                        r_state     <= StLocked;
                        r_req_ready <= 1'b1;
                    end else if (w_commit) begin
                        r_mux         <= r_target;
                        r_switch_done <= 1'b1;
                        r_state       <= StLocked;
                        r_req_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= StLocked;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready & ~w_auto_req;
    assign req_err     = r_req_err;
    assign switch_done = r_switch_done;
    assign mux_ctrl    = r_mux;

endmodule

// File: tb/tb_ts_source_scheduler.sv
// Directed bench for ts_source_scheduler: a vector table for single-cycle
// behaviour plus streamed multi-cycle sequences with a muxed-packet checker.
module tb_ts_source_scheduler;
    import ts_sched_pkg::*;

    localparam int PKT = PKT_LEN;

    logic       wclk = 1'b0;
    logic       rst;
    logic [3:0] valid_in;
    logic [3:0] sync_in;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic       req_err;
    logic       switch_done;
    logic [1:0] mux_ctrl;
    logic [3:0] src_alive;
    logic [3:0] sync_err;

    int n_cmp  = 0;
    int n_fail = 0;

    int   ch_pos[4];
    int   ch_period[4];
    bit   ch_en[4];
    bit   force_sync[4];
    bit   mon_armed;
    int   mon_run;
    logic [3:0] se_seen;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] sync;
        logic       rv;
        logic [1:0] rs;
        logic [1:0] mux;
        logic       ready;
        logic       err;
        logic       done;
        logic [3:0] alive;
        logic [3:0] serr;
    } vec_t;

    vec_t tbl[13];

    ts_source_scheduler u_dut (
        .wclk       (wclk),
        .rst        (rst),
        .valid_in   (valid_in),
        .sync_in    (sync_in),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .req_err    (req_err),
        .switch_done(switch_done),
        .mux_ctrl   (mux_ctrl),
        .src_alive  (src_alive),
        .sync_err   (sync_err)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every muxed packet must start with sync and be exactly PKT bytes long.
    task automatic mon_byte(input logic v, input logic s);
        if (v) begin
            if (s) begin
                if (mon_armed) chk("pkt_len", mon_run, PKT);
                mon_armed = 1'b1;
                mon_run   = 1;
            end else if (mon_armed) begin
                chk("pkt_in_frame", 32'(mon_run < PKT), 1);
                mon_run++;
            end
        end
    endtask

    task automatic step();
        logic [3:0] v;
        logic [3:0] s;
        for (int i = 0; i < 4; i++) begin
            if (force_sync[i]) ch_pos[i] = 0;
            v[i] = ch_en[i] && (ch_pos[i] < PKT);
            s[i] = v[i] && (ch_pos[i] == 0);
        end
        valid_in = v;
        sync_in  = s;
        mon_byte(v[mux_ctrl], s[mux_ctrl]);
        @(posedge wclk);
        #1;
        se_seen = se_seen | sync_err;
        for (int i = 0; i < 4; i++) begin
            if (ch_en[i]) ch_pos[i] = (ch_pos[i] + 1) % ch_period[i];
            force_sync[i] = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        valid_in  = 4'h0;
        sync_in   = 4'h0;
        req_valid = 1'b0;
        req_sel   = 2'd0;
        @(posedge wclk);
        #1;
        rst       = 1'b0;
        mon_armed = 1'b0;
        mon_run   = 0;
        se_seen   = 4'h0;
        for (int i = 0; i < 4; i++) begin
            ch_en[i]      = 1'b0;
            force_sync[i] = 1'b0;
            ch_period[i]  = 200;
            ch_pos[i]     = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        valid_in  = 4'h0;
        sync_in   = 4'h0;
        req_valid = 1'b0;
        req_sel   = 2'd0;

        //           rst valid sync rv rs   mux rdy err done alive serr
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'h1, 4'h1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0};
        tbl[2]  = '{1'b0, 4'h1, 4'h1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h1};
        tbl[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0};
        tbl[4]  = '{1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 4'h1, 4'h0};
        tbl[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0};
        tbl[6]  = '{1'b0, 4'h0, 4'h0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0};
        tbl[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0};
        tbl[8]  = '{1'b0, 4'h4, 4'h4, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h5, 4'h0};
        tbl[9]  = '{1'b0, 4'h0, 4'h0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0};
        tbl[10] = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0};
        tbl[12] = '{1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};

        for (int i = 0; i < 13; i++) begin
            rst       = tbl[i].rst;
            valid_in  = tbl[i].valid;
            sync_in   = tbl[i].sync;
            req_valid = tbl[i].rv;
            req_sel   = tbl[i].rs;
            @(posedge wclk);
            #1;
            chk($sformatf("v%0d_mux", i), 32'(mux_ctrl), 32'(tbl[i].mux));
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            chk($sformatf("v%0d_err", i), 32'(req_err), 32'(tbl[i].err));
            chk($sformatf("v%0d_done", i), 32'(switch_done), 32'(tbl[i].done));
            chk($sformatf("v%0d_alive", i), 32'(src_alive), 32'(tbl[i].alive));
            chk($sformatf("v%0d_serr", i), 32'(sync_err), 32'(tbl[i].serr));
        end

        // ch0 and ch2 streaming (period 200, ch2 five cycles behind); switch to ch2.
        do_reset();
        ch_en[0]  = 1'b1;
        ch_en[2]  = 1'b1;
        ch_pos[2] = 195;
        for (int s = 1; s <= 420; s++) begin
            if (s == 50)  begin req_valid = 1'b1; req_sel = 2'd2; end
            if (s == 250) begin req_valid = 1'b1; req_sel = 2'd3; end
            step();
            if (s == 1) begin
                chk("t2_alive_ch0", 32'(src_alive), 32'h1);
                chk("t2_mux_init", 32'(mux_ctrl), 0);
            end
            if (s == 6)   chk("t2_alive_ch02", 32'(src_alive), 32'h5);
            if (s == 50)  chk("t2_pending_ready", 32'(req_ready), 0);
            if (s == 192) begin
                chk("t2_mux_before", 32'(mux_ctrl), 0);
                chk("t2_done_before", 32'(switch_done), 0);
            end
            if (s == 193) begin
                chk("t2_mux_commit", 32'(mux_ctrl), 2);
                chk("t2_done_commit", 32'(switch_done), 1);
                chk("t2_ready_commit", 32'(req_ready), 1);
            end
            if (s == 194) begin
                chk("t2_done_pulse", 32'(switch_done), 0);
                chk("t2_mux_hold", 32'(mux_ctrl), 2);
            end
            if (s == 250) begin
                chk("t3_err", 32'(req_err), 1);
                chk("t3_mux", 32'(mux_ctrl), 2);
                chk("t3_ready", 32'(req_ready), 1);
            end
            if (s == 251) chk("t3_err_pulse", 32'(req_err), 0);
        end
        chk("t2_no_sync_err", 32'(se_seen), 0);

        // ch1 resync at byte 100; packet boundary moves to 188 bytes after it.
        ch_en[1]     = 1'b1;
        ch_pos[1]    = 0;
        ch_period[1] = PKT;
        run_steps(99);
        force_sync[1] = 1'b1;
        step();
        chk("t4_resync_err", 32'(sync_err), 32'h2);
        step();
        chk("t4_resync_pulse", 32'(sync_err), 0);
        run_steps(185);
        force_sync[1] = 1'b1;
        step();
        chk("t4_still_in_pkt", 32'(sync_err), 32'h2);
        run_steps(187);
        step();
        chk("t4_boundary_188", 32'(sync_err), 0);
        chk("t4_alive", 32'(src_alive), 32'h7);

        // ch0 selected then silent; ch2 keeps streaming.
        do_reset();
        ch_en[0]  = 1'b1;
        ch_en[2]  = 1'b1;
        ch_pos[2] = 195;
        for (int s = 1; s <= 4200; s++) begin
            if (s == 189) ch_en[0] = 1'b0;
            step();
            if (s == 4096) begin
                chk("t5_alive_before", 32'(src_alive), 32'h5);
                chk("t5_mux_before", 32'(mux_ctrl), 0);
            end
            if (s == 4097) chk("t5_alive_dead", 32'(src_alive), 32'h4);
`ifdef AUTO_FAILOVER_EN
            if (s == 4097) chk("t5_auto_ready", 32'(req_ready), 0);
            if (s == 4192) chk("t5_auto_mux_before", 32'(mux_ctrl), 0);
            if (s == 4193) begin
                chk("t5_auto_mux", 32'(mux_ctrl), 2);
                chk("t5_auto_done", 32'(switch_done), 1);
            end
`else
            if (s == 4097) chk("t5_ready", 32'(req_ready), 1);
            if (s == 4193) begin
                chk("t5_mux_hold", 32'(mux_ctrl), 0);
                chk("t5_no_done", 32'(switch_done), 0);
            end
`endif
        end

        // PENDING toward ch1, which dies mid-packet before it can commit.
        do_reset();
        ch_en[0]     = 1'b1;
        ch_en[1]     = 1'b1;
        ch_period[1] = PKT;
        for (int s = 1; s <= 4100; s++) begin
            if (s == 2) begin req_valid = 1'b1; req_sel = 2'd1; end
            step();
            if (s == 1) ch_en[1] = 1'b0;
            if (s == 2) chk("t6_pending", 32'(req_ready), 0);
            if (s == 4096) begin
                chk("t6_ready_wait", 32'(req_ready), 0);
                chk("t6_err_wait", 32'(req_err), 0);
            end
            if (s == 4097) begin
                chk("t6_abort_err", 32'(req_err), 1);
                chk("t6_abort_mux", 32'(mux_ctrl), 0);
                chk("t6_abort_ready", 32'(req_ready), 1);
                chk("t6_abort_done", 32'(switch_done), 0);
                chk("t6_abort_alive", 32'(src_alive), 32'h1);
            end
            if (s == 4098) chk("t6_err_pulse", 32'(req_err), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ts_source_scheduler.md
Name: ts_source_scheduler

Overview:
Packet-aligned controller driving mux_ctrl of the 4-channel TS output path (mux → async FIFO) in the 27 MHz write domain. Tracks 188-byte TS packet framing on all four input channels and monitors liveness per channel. Accepts host source-select requests and commits a switch only when the current and target channels are both between packets, so the output FIFO never receives a torn packet.

Parameters:
PKT_LEN, 188, bytes per TS packet; sync byte counts as byte 1.
CNT_W, 8, width of the per-channel byte counter; must satisfy 2^CNT_W > PKT_LEN.
TIMEOUT_CYCLES, 4096, wclk cycles without a valid sync before a channel is declared dead.
TO_W, 13, width of the per-channel timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
wclk  in  1  27 MHz write-domain clock.
rst  in  1  synchronous reset, active-high.
valid_in  in  4  per-channel byte valid (bit i = channel i).
sync_in  in  4  per-channel sync marker, qualified by valid_in.
req_valid  in  1  host select request.
req_sel  in  2  requested channel.
req_ready  out  1  high when a request is accepted this cycle (LOCKED state).
req_err  out  1  1-cycle pulse: request rejected or aborted.
switch_done  out  1  1-cycle pulse: mux_ctrl updated to the new channel.
mux_ctrl  out  2  registered channel select to the data/valid/sync muxes.
src_alive  out  4  per-channel liveness.
sync_err  out  4  1-cycle pulse per channel: sync seen mid-packet.

Behaviour:
- Reset values: mux_ctrl=0, req_ready=1, req_err=0, switch_done=0, src_alive=0, sync_err=0. All counters cleared; in_pkt=0; FSM enters LOCKED. Reset mid-switch discards the pending request.
- Framing, per channel i, evaluated on valid_in[i] only:
  - sync with in_pkt=0: cnt=1, in_pkt=1.
  - sync with in_pkt=1: cnt=1, sync_err[i] pulses (resync).
  - non-sync with in_pkt=1: cnt+1; when cnt+1 reaches PKT_LEN, cnt=0 and in_pkt=0.
  - non-sync with in_pkt=0: ignored.
- in_pkt_nxt[i] is the combinational next value of in_pkt[i].
- Liveness: timeout counter cleared on valid&sync and src_alive[i] set to 1 the next cycle. Otherwise the counter increments, saturating at TIMEOUT_CYCLES. When it reaches TIMEOUT_CYCLES: src_alive[i]=0, in_pkt[i]=0, cnt[i]=0.
- FSM LOCKED (req_ready=1). On req_valid:
  - req_sel==mux_ctrl: switch_done pulses next cycle, stay LOCKED.
  - src_alive[req_sel]=0: req_err pulses, stay LOCKED.
  - otherwise: latch target, go to PENDING.
- FSM PENDING (req_ready=0; req_valid ignored):
  - Commit condition: (in_pkt_nxt[mux_ctrl]=0 or src_alive[mux_ctrl]=0) and in_pkt_nxt[target]=0.
  - On commit, at the next edge: mux_ctrl<=target, switch_done pulses, return to LOCKED.
  - Consequence: the first byte the new channel presents through the mux is its sync byte.
  - If the target goes dead while PENDING: req_err pulses, return to LOCKED, mux_ctrl unchanged.
  - If commit and target-death coincide in the same cycle: death wins (abort).
- Switch latency: 1 cycle after the commit condition; minimum 2 cycles from req_valid.

Optional Feature:
AUTO_FAILOVER_EN
- Defined: in LOCKED, if src_alive[mux_ctrl] falls to 0 and any channel is alive, an internal request targets the lowest-index alive channel. It runs through PENDING exactly like a host request; a host req_valid in the same cycle is ignored (req_ready=0 that cycle). If no channel is alive, mux_ctrl holds.
- Undefined: a dead current channel only changes src_alive; mux_ctrl holds until a host request.

Decomposition:
- Package ts_sched_pkg: PKT_LEN, state enum (LOCKED, PENDING), channel-count constant 4, sync byte value 8'h47 for bench checking.
- One natural sub-module, ts_chan_monitor, instantiated 4×: framing counter, in_pkt, in_pkt_nxt, timeout counter, src_alive, sync_err. The top holds the FSM and mux_ctrl register.

Test Plan:
- Reset, then a continuous packet on ch0 (sync + 187 bytes) → src_alive=0001 one cycle after the sync, mux_ctrl=0, no sync_err.
- ch0 and ch2 streaming with offset phases; req_sel=2 issued at ch0 byte 50 → mux_ctrl=2 exactly one cycle after both channels are between packets; switch_done single pulse; the muxed stream has no partial packet (bench checks every output packet is 188 bytes starting 0x47).
- req_sel=3 with ch3 never synced → req_err pulse next cycle, mux_ctrl unchanged, req_ready stays 1.
- ch1 sync at byte 100 of an ongoing packet → sync_err[1] pulse, cnt restarts at 1, next packet boundary 188 bytes later.
- ch0 selected; stop ch0 valid for TIMEOUT_CYCLES → src_alive[0]=0 at cycle 4096. With AUTO_FAILOVER_EN and ch2 alive → mux_ctrl=2 at ch2's next between-packet point. Without the macro → mux_ctrl stays 0.
- PENDING toward ch1, then ch1 times out before commit → req_err pulse, FSM back to LOCKED, mux_ctrl unchanged. Assert rst mid-PENDING → all outputs at reset values the next cycle.
